lut_neuron_array: RTL and testbench

Parametrised, runtime-reloadable successor to the fixed single-neuron truth-table ROMs emitted per layer. It instantiates NUM_NEURONS independent lookup tables, each mapping an IN_BITS input word to an OUT_BITS activation. Tables are loaded through a write port instead of being fixed at synthesis. It sits between layer registers in the generated network and streams one input vector per cycle through a 2-stage pipeline with valid/ready backpressure.

---
 rtl/lut_neuron_array.sv | 83 ++++++++
 tb/tb_lut_neuron_array.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_array.sv
// Array of runtime-loadable per-neuron lookup tables, streamed through a
// 2-stage valid/ready pipeline (S1 = address capture, S2 = table read).
module lut_neuron_lane #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [IN_BITS-1:0]  i_waddr,
  input  logic [OUT_BITS-1:0] i_wdata,
  input  logic [IN_BITS-1:0]  i_raddr,
  input  logic                i_ld,
  output logic [OUT_BITS-1:0] o_q
);
  logic [OUT_BITS-1:0] r_mem [2**IN_BITS];
  logic [OUT_BITS-1:0] r_q;

  // Table survives reset; only the output register is cleared.
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  // Asynchronous read sampled on the write edge yields the pre-write value.
  always_ff @(posedge i_clk)
    if (i_rst)     r_q <= '0;
    else if (i_ld) r_q <= r_mem[i_raddr];

  assign o_q = r_q;
endmodule

module lut_neuron_array #(
  parameter int NUM_NEURONS = 4,
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 1,
  parameter int SEL_BITS    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_cfg_we,
  input  logic [SEL_BITS-1:0]             i_cfg_sel,
  input  logic [IN_BITS-1:0]              i_cfg_addr,
  input  logic [OUT_BITS-1:0]             i_cfg_data,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  i_in_data,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] o_out_data
);
  logic                                   w_adv;
  logic                                   w_acc;
  logic [1:0]                             r_vld_pipe;  // [0] = S1, [1] = S2
  logic [NUM_NEURONS-1:0][IN_BITS-1:0]    r_s1_addr;
  logic [NUM_NEURONS-1:0][OUT_BITS-1:0]   w_q;

  assign w_adv      = !r_vld_pipe[1] || i_out_ready;
  assign o_in_ready = w_adv && !i_cfg_we && !i_rst;
  assign w_acc      = i_in_valid && o_in_ready;

  always_ff @(posedge i_clk)
    if (i_rst)      r_vld_pipe <= '0;
    else if (w_adv) r_vld_pipe <= {r_vld_pipe[0], w_acc};

  always_ff @(posedge i_clk)
    if (w_acc) r_s1_addr <= i_in_data;

  // Out-of-range selects match no lane, so the write simply vanishes.
  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lane
    lut_neuron_lane #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_lane (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (i_cfg_we && (i_cfg_sel == SEL_BITS'(g))),
      .i_waddr (i_cfg_addr),
      .i_wdata (i_cfg_data),
      .i_raddr (r_s1_addr[g]),
      .i_ld    (w_adv && r_vld_pipe[0]),
      .o_q     (w_q[g])
    );
  end

  assign o_out_valid = r_vld_pipe[1];
  assign o_out_data  = w_q;
endmodule

// File: tb/tb_lut_neuron_array.sv
// Directed bench for lut_neuron_array: parity tables with a scoreboard on the
// default instance, plus small instances for select range and odd widths.
module tb_lut_neuron_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: 4 x 8 -> 1 ----------------
  logic        a_we = 0, a_wd = 0, a_iv = 0, a_ord = 1;
  logic [1:0]  a_sel = 0;
  logic [7:0]  a_addr = 0;
  logic [31:0] a_din = 0;
  logic        a_ird, a_ov;
  logic [3:0]  a_dout;

  lut_neuron_array u_a (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(a_we), .i_cfg_sel(a_sel),
    .i_cfg_addr(a_addr), .i_cfg_data(a_wd), .i_in_valid(a_iv),
    .o_in_ready(a_ird), .i_in_data(a_din), .o_out_valid(a_ov),
    .i_out_ready(a_ord), .o_out_data(a_dout));

  // ---------------- instance B: 3 x 2 -> 1 ----------------
  logic        b_we = 0, b_wd = 0, b_iv = 0;
  logic [1:0]  b_sel = 0, b_addr = 0;
  logic [5:0]  b_din = 0;
  logic        b_ird, b_ov;
  logic [2:0]  b_dout;

  lut_neuron_array #(.NUM_NEURONS(3), .IN_BITS(2), .OUT_BITS(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(b_we), .i_cfg_sel(b_sel),
    .i_cfg_addr(b_addr), .i_cfg_data(b_wd), .i_in_valid(b_iv),
    .o_in_ready(b_ird), .i_in_data(b_din), .o_out_valid(b_ov),
    .i_out_ready(1'b1), .o_out_data(b_dout));

  // ---------------- instance C: 2 x 4 -> 3 ----------------
  logic        c_we = 0, c_iv = 0;
  logic [0:0]  c_sel = 0;
  logic [3:0]  c_addr = 0;
  logic [2:0]  c_wd = 0;
  logic [7:0]  c_din = 0;
  logic        c_ird, c_ov;
  logic [5:0]  c_dout;

  lut_neuron_array #(.NUM_NEURONS(2), .IN_BITS(4), .OUT_BITS(3)) u_c (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(c_we), .i_cfg_sel(c_sel),
    .i_cfg_addr(c_addr), .i_cfg_data(c_wd), .i_in_valid(c_iv),
    .o_in_ready(c_ird), .i_in_data(c_din), .o_out_valid(c_ov),
    .i_out_ready(1'b1), .o_out_data(c_dout));

  // ---------------- model + scoreboard for A ----------------
  logic       mdl [4][256];
  logic [3:0] exp_q [$];
  int         n_out = 0, n_acc = 0;
  logic       stall_prev = 0;
  logic [3:0] held = 0;

  function automatic logic [3:0] mdl_out(input logic [31:0] d);
    logic [3:0] r;
    for (int n = 0; n < 4; n++) r[n] = mdl[n][d[n*8 +: 8]];
    return r;
  endfunction

  // Inputs change just after posedge, so negedge sees what the next edge will do.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (a_ov && a_ord) begin
        if (exp_q.size() == 0) chk("extra_out", 1, 0);
        else chk("a_out", a_dout, exp_q.pop_front());
        n_out++;
      end
      if (stall_prev) begin
        chk("stall_vld", a_ov, 1);
        chk("stall_dat", a_dout, held);
      end
      if (a_iv && a_ird) begin
        exp_q.push_back(mdl_out(a_din));
        n_acc++;
      end
      if (a_we) mdl[a_sel][a_addr] = a_wd;
    end
    stall_prev = a_ov && !a_ord && !rst;
    held       = a_dout;
  end

  task automatic a_drv(input logic we, input logic [1:0] sel, input logic [7:0] addr,
                       input logic wd, input logic iv, input logic [31:0] din, input logic ord);
    @(posedge clk); #1;
    a_we = we; a_sel = sel; a_addr = addr; a_wd = wd; a_iv = iv; a_din = din; a_ord = ord;
  endtask

  task automatic b_drv(input logic we, input logic [1:0] sel, input logic [1:0] addr,
                       input logic wd, input logic iv, input logic [5:0] din);
    @(posedge clk); #1;
    b_we = we; b_sel = sel; b_addr = addr; b_wd = wd; b_iv = iv; b_din = din;
  endtask

  task automatic c_drv(input logic we, input logic sel, input logic [3:0] addr,
                       input logic [2:0] wd, input logic iv, input logic [7:0] din);
    @(posedge clk); #1;
    c_we = we; c_sel = sel; c_addr = addr; c_wd = wd; c_iv = iv; c_din = din;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc0, out0, i, cyc;
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    logic [7:0]  av;
    logic [31:0] v;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", a_ov, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_ird", a_ird, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("ird_after_rst", a_ird, 1);

    // parity tables
    for (int n = 0; n < 4; n++)
      for (int a = 0; a < 256; a++) begin
        av = 8'(a);
        a_drv(1, 2'(n), av, ^av, 0, '0, 1);
      end

    // directed parity vector: FF->0, 03->0, 01->1, 00->0
    a_drv(0, 0, 0, 0, 1, 32'h0001_03FF, 1);
    a_drv(0, 0, 0, 0, 0, '0, 1);
    @(posedge clk); #1;
    chk("par_ov", a_ov, 1);
    chk("par_dout", a_dout, 4'b0100);

    // back-to-back random stream
    acc0 = n_acc;
    for (int k = 0; k < 256; k++) a_drv(0, 0, 0, 0, 1, $urandom, 1);
    repeat (4) a_drv(0, 0, 0, 0, 0, '0, 1);
    chk("thru_acc", n_acc - acc0, 256);
    chk("thru_drain", exp_q.size(), 0);

    // backpressure: vector i makes neuron n output bit n of i
    out0 = n_out; i = 0; cyc = 0;
    while (i < 10 && cyc < 200) begin
      for (int n = 0; n < 4; n++) v[n*8 +: 8] = i[n] ? 8'h01 : 8'h00;
      a_drv(0, 0, 0, 0, 1, v, pat[cyc % 6] != 0);
      @(negedge clk);
      if (a_ird) i++;
      cyc++;
    end
    repeat (5) a_drv(0, 0, 0, 0, 0, '0, 1);
    chk("bp_count", n_out - out0, 10);
    chk("bp_drain", exp_q.size(), 0);

    // read/write collision on table[0][5A]
    a_drv(0, 0, 0, 0, 1, 32'h0000_005A, 1);
    a_drv(1, 0, 8'h5A, 1, 0, '0, 1);
    @(negedge clk);
    chk("coll_ird", a_ird, 0);
    a_drv(0, 0, 0, 0, 1, 32'h0000_005A, 1);
    chk("coll_old_ov", a_ov, 1);
    chk("coll_old", a_dout, 4'b0000);
    a_drv(0, 0, 0, 0, 0, '0, 1);
    chk("bubble_ov", a_ov, 0);
    chk("bubble_hold", a_dout, 4'b0000);
    a_drv(0, 0, 0, 0, 0, '0, 1);
    chk("coll_new_ov", a_ov, 1);
    chk("coll_new", a_dout, 4'b0001);
    repeat (2) a_drv(0, 0, 0, 0, 0, '0, 1);

    // reset with S1 and S2 both valid
    a_drv(0, 0, 0, 0, 1, 32'h0101_0101, 0);
    a_drv(0, 0, 0, 0, 1, 32'h0000_0101, 0);
    a_drv(0, 0, 0, 0, 0, '0, 0);
    rst = 1;
    @(negedge clk);
    chk("pre_rst_ov", a_ov, 1);
    @(posedge clk); #1;
    rst = 0; a_ord = 1;
    chk("mid_rst_ov", a_ov, 0);
    chk("mid_rst_dout", a_dout, 0);
    out0 = n_out;
    repeat (4) a_drv(0, 0, 0, 0, 0, '0, 1);
    chk("no_stale", n_out - out0, 0);
    a_drv(0, 0, 0, 0, 1, 32'h0000_0301, 1);
    a_drv(0, 0, 0, 0, 0, '0, 1);
    @(posedge clk); #1;
    chk("post_rst_ov", a_ov, 1);
    chk("post_rst_dout", a_dout, 4'b0001);

    // B: addr 0 entries 0, others 1; then an out-of-range write
    for (int n = 0; n < 3; n++)
      for (int a = 0; a < 4; a++) b_drv(1, 2'(n), 2'(a), a != 0, 0, '0);
    b_drv(1, 2'd3, 2'd0, 1, 0, '0);
    b_drv(0, 0, 0, 0, 1, 6'b00_00_00);
    b_drv(0, 0, 0, 0, 1, 6'b01_01_01);
    b_drv(0, 0, 0, 0, 0, '0);
    chk("oor_addr0", b_dout, 3'b000);
    b_drv(0, 0, 0, 0, 0, '0);
    chk("oor_ov", b_ov, 1);
    chk("oor_addr1", b_dout, 3'b111);

    // C: entry = ~addr[2:0]
    for (int n = 0; n < 2; n++)
      for (int a = 0; a < 16; a++) begin
        av = 8'(a);
        c_drv(1, n[0], av[3:0], ~av[2:0], 0, '0);
      end
    c_drv(0, 0, 0, 0, 1, 8'h7C);
    c_drv(0, 0, 0, 0, 1, 8'h30);
    c_drv(0, 0, 0, 0, 0, '0);
    chk("wide_7c", c_dout, 6'b000_011);
    c_drv(0, 0, 0, 0, 0, '0);
    chk("wide_ov", c_ov, 1);
    chk("wide_30", c_dout, 6'b100_111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
